fdiv_sched: RTL and testbench
=============================

FDIV_SCHED -- requirements
Module: fdiv_sched

Interface
REQ-001 Parameter: LATENCY, default 16, cycles from div_start to a valid div_q on the shared iterative divider; legal range 2..31.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 divide request; held high until done0.
REQ-005 a0, b0  input  24 each  requester 0 dividend and divisor mantissas.
REQ-006 req1  input  1  requester 1 divide request; held high until done1.
REQ-007 a1, b1  input  24 each  requester 1 dividend and divisor mantissas.
REQ-008 div_q  input  32  quotient from the shared divider datapath.
REQ-009 div_start  output  1  one-cycle start pulse to the divider.
REQ-010 div_a, div_b  output  24 each  registered operands driven to the divider.
REQ-011 q_out  output  32  registered quotient returned to the granted requester.
REQ-012 done0, done1  output  1 each  one-cycle completion pulse per requester.
REQ-013 stall0, stall1  output  1 each  pipeline hold per requester.
REQ-014 busy  output  1  divider occupied.
REQ-015 grant_id  output  1  index of the requester that owns the current operation.

Function
REQ-016 FSM states: IDLE, START, RUN, DONE; busy SHALL be high in every state except IDLE.
REQ-017 IDLE: if no request is pending, the FSM SHALL stay in IDLE.
REQ-018 IDLE with exactly one request: grant that requester.
REQ-019 IDLE with both requests: grant the requester not granted most recently; rr pointer SHALL be 0 after reset, so requester 0 wins the first tie.
REQ-020 On grant edge: latch grant_id and the granted operands into div_a/div_b, then move to START.
REQ-021 START lasts exactly one cycle with div_start=1, then moves to RUN with a 5-bit counter set to 1.
REQ-022 RUN: the counter SHALL increment by 1 each cycle.
REQ-023 RUN exit: on the edge where counter==LATENCY, capture q_out<=div_q and move to DONE.
REQ-024 DONE lasts exactly one cycle: pulse done[grant_id], update the rr pointer to grant_id, then return to IDLE.
REQ-025 Latency: request sampled at edge k gives div_start in cycle k+1, done in cycle k+LATENCY+2, and q_out valid from that cycle until the next capture.
REQ-026 stall_i = req_i & ~done_i, combinational.
REQ-027 A requester SHALL see stall low only in its own done cycle.
REQ-028 div_a, div_b, grant_id and q_out SHALL hold stable outside their update edges.
REQ-029 A request arriving, or switching sides, while busy SHALL NOT affect the current operation; it is arbitrated in the next IDLE cycle.
REQ-030 Minimum spacing between consecutive div_start pulses is LATENCY+3 cycles, with one mandatory IDLE cycle after DONE.
REQ-031 Request dropped while busy: the operation SHALL complete and done SHALL still pulse.
REQ-032 Request dropped while busy: the requester is not required to consume the result.
REQ-033 Requester still high in the IDLE cycle after its done: treat it as a new request.
REQ-034 div_start SHALL never assert while the FSM is in RUN or DONE.

Reset
REQ-035 While rst=1 at an edge: state<=IDLE, counter<=0, rr pointer<=0, grant_id<=0.
REQ-036 While rst=1 at an edge: div_a, div_b and q_out SHALL be 0.
REQ-037 While rst=1 at an edge: div_start, done0, done1 and busy SHALL be 0.
REQ-038 Reset mid-operation SHALL abort without a done pulse; div_q is ignored.
REQ-039 During reset, stall_i SHALL follow req_i.

Verification
REQ-040 Single request, LATENCY=16: req0=1, a0=0x800000, b0=0xC00000, model div_q=0x2AAAAAAB -> div_start cycle 1, div_a=0x800000, div_b=0xC00000, done0 cycle 18, q_out=0x2AAAAAAB, stall0 low only in cycle 18.
REQ-041 Tie after reset: req0=req1=1 from cycle 0 -> requester 0 first (done0 cycle 18); requester 1 div_start cycle 20, done1 cycle 37, grant_id=1.
REQ-042 Persistent contention: both requesters re-request immediately for 4 operations -> grants alternate 0,1,0,1; div_start spacing = 19 cycles.
REQ-043 Reset mid-run: assert rst at RUN counter=7 -> next cycle busy=0, all outputs 0, no done pulse.
REQ-044 Reset mid-run, then req1 alone -> requester 1 granted normally.
REQ-045 Drop mid-run and late arrival: req0 dropped at counter=3 and req1 raised at counter=5 -> done0 still pulses; grant_id stays 0; req1 granted in the following IDLE cycle.

Source files
------------

// File: rtl/fdiv_sched.sv
// fdiv_sched: shares one iterative divider between two requesters.
// A round-robin arbiter picks a requester in IDLE, latches its operands,
// pulses div_start, waits LATENCY cycles, captures the quotient and pulses
// that requester's done. There is always one IDLE cycle between operations.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req0/a0/b0        requester 0 request and mantissa operands
//   req1/a1/b1        requester 1 request and mantissa operands
//   div_q             quotient from the shared divider datapath
//   div_start         one-cycle start pulse to the divider
//   div_a, div_b      registered operands driven to the divider
//   q_out             registered quotient for the granted requester
//   done0, done1      one-cycle completion pulse per requester
//   stall0, stall1    combinational pipeline hold per requester
//   busy              divider occupied (any state but IDLE)
//   grant_id          owner of the current / most recent operation
module fdiv_sched #(
  parameter int unsigned LATENCY = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [23:0] a0,
  input  logic [23:0] b0,
  input  logic        req1,
  input  logic [23:0] a1,
  input  logic [23:0] b1,
  input  logic [31:0] div_q,
  output logic        div_start,
  output logic [23:0] div_a,
  output logic [23:0] div_b,
  output logic [31:0] q_out,
  output logic        done0,
  output logic        done1,
  output logic        stall0,
  output logic        stall1,
  output logic        busy,
  output logic        grant_id
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rr_last;   // requester granted most recently
  logic             rr_valid;  // a grant has completed since reset
  logic             pick;

  // Arbitration: a lone request wins; on a tie the side not granted last
  // wins, with requester 0 winning the first tie after reset.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = rr_valid ? ~rr_last : 1'b0;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  // Hold each requester until its own done cycle.
  assign stall0 = req0 & ~done0;
  assign stall1 = req1 & ~done1;

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_last   <= 1'b0;
      rr_valid  <= 1'b0;
      grant_id  <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      q_out     <= '0;
      div_start <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      div_start <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant_id  <= pick;
            div_a     <= pick ? a1 : a0;
            div_b     <= pick ? b1 : b0;
            div_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          cnt   <= CNT_W'(1);
          state <= RUN;
        end
        RUN: begin
          if (cnt == LAT_CNT) begin
            q_out <= div_q;
            done0 <= ~grant_id;
            done1 <= grant_id;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          rr_last  <= grant_id;
          rr_valid <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_sched.sv
module tb_fdiv_sched;

  localparam int unsigned LAT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [23:0] a0, b0, a1, b1;
  logic [31:0] div_q;
  logic        div_start;
  logic [23:0] div_a, div_b;
  logic [31:0] q_out;
  logic        done0, done1, stall0, stall1, busy, grant_id;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ts[4];
  int t_tmp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fdiv_sched #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .div_q(div_q), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .q_out(q_out), .done0(done0), .done1(done1),
    .stall0(stall0), .stall1(stall1), .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first IDLE cycle after reset.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Starts in the IDLE cycle where the grant happens; ends in the DONE cycle.
  task automatic op_check(input logic id, input logic [23:0] ea, input logic [23:0] eb,
                          input logic [31:0] eq, input string tag, output int t_start);
    step();
    t_start = cyc;
    chk1({tag, ".div_start"}, div_start, 1'b1);
    chk1({tag, ".grant_id"}, grant_id, id);
    chk({tag, ".div_a"}, 32'(div_a), 32'(ea));
    chk({tag, ".div_b"}, 32'(div_b), 32'(eb));
    chk1({tag, ".busy_start"}, busy, 1'b1);
    for (int i = 1; i <= int'(LAT); i++) begin
      step();
      chk1({tag, ".run_start"}, div_start, 1'b0);
      chk({tag, ".run_done"}, 32'({done1, done0}), 32'(0));
      chk1({tag, ".run_busy"}, busy, 1'b1);
      chk1({tag, ".run_grant"}, grant_id, id);
    end
    step();
    chk({tag, ".done"}, 32'({done1, done0}), id ? 32'(2) : 32'(1));
    chk({tag, ".q_out"}, q_out, eq);
    chk1({tag, ".done_busy"}, busy, 1'b1);
    chk1({tag, ".done_stall"}, id ? stall1 : stall0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; div_q = '0;

    // Single request and reset state
    do_reset();
    req0 = 1'b1; a0 = 24'h800000; b0 = 24'hC00000; div_q = 32'h2AAAAAAB;
    #1;
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.div_start", div_start, 1'b0);
    chk("rst.done", 32'({done1, done0}), 32'(0));
    chk("rst.div_a", 32'(div_a), 32'(0));
    chk("rst.div_b", 32'(div_b), 32'(0));
    chk("rst.q_out", q_out, 32'(0));
    chk1("rst.grant_id", grant_id, 1'b0);
    chk1("rst.stall0", stall0, 1'b1);
    chk1("rst.stall1", stall1, 1'b0);
    op_check(1'b0, 24'h800000, 24'hC00000, 32'h2AAAAAAB, "single", t_tmp);
    chk("single.done_cycle", 32'(t_tmp + 17), 32'(cyc));
    req0 = 1'b0;
    step();
    chk1("single.idle_busy", busy, 1'b0);
    chk("single.idle_done", 32'({done1, done0}), 32'(0));
    chk("single.q_hold", q_out, 32'h2AAAAAAB);
    step();
    chk1("single.stay_idle", div_start, 1'b0);
    chk1("single.stay_busy", busy, 1'b0);

    // Tie after reset, then persistent contention
    do_reset();
    chk("tie.q_cleared", q_out, 32'(0));
    req0 = 1'b1; req1 = 1'b1;
    a0 = 24'h123456; b0 = 24'h0ABCDE; a1 = 24'h654321; b1 = 24'h7FFFFF;
    div_q = 32'h11111111;
    for (int k = 0; k < 4; k++) begin
      if (k[0]) op_check(1'b1, 24'h654321, 24'h7FFFFF, 32'h11111111 * 32'(k + 1), "rr", ts[k]);
      else      op_check(1'b0, 24'h123456, 24'h0ABCDE, 32'h11111111 * 32'(k + 1), "rr", ts[k]);
      div_q = 32'h11111111 * 32'(k + 2);
      step();
      chk1("rr.idle_busy", busy, 1'b0);
      chk1("rr.idle_stall0", stall0, 1'b1);
      chk1("rr.idle_stall1", stall1, 1'b1);
      if (k > 0) chk("rr.spacing", 32'(ts[k] - ts[k - 1]), 32'(19));
    end
    chk("tie.first_start", 32'(ts[1] - ts[0]), 32'(19));
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk1("rr.quiet", busy, 1'b0);

    // Reset mid-run, then requester 1 alone
    req0 = 1'b1; a0 = 24'hABCDEF; b0 = 24'h000001; div_q = 32'hDEADBEEF;
    step();
    chk1("abort.start", div_start, 1'b1);
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    req1 = 1'b1;
    #1;
    chk1("abort.busy", busy, 1'b0);
    chk1("abort.div_start", div_start, 1'b0);
    chk("abort.done", 32'({done1, done0}), 32'(0));
    chk("abort.div_a", 32'(div_a), 32'(0));
    chk("abort.div_b", 32'(div_b), 32'(0));
    chk("abort.q_out", q_out, 32'(0));
    chk1("abort.grant_id", grant_id, 1'b0);
    chk1("abort.stall0", stall0, 1'b1);
    chk1("abort.stall1", stall1, 1'b1);
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      step();
      chk("abort.no_done", 32'({done1, done0, busy}), 32'(0));
    end
    rst = 1'b0; req0 = 1'b0; div_q = 32'hCAFEF00D;
    op_check(1'b1, 24'h654321, 24'h7FFFFF, 32'hCAFEF00D, "after_rst", t_tmp);
    req1 = 1'b0;
    step();
    chk1("after_rst.idle", busy, 1'b0);

    // Drop mid-run and late arrival on the other side
    req0 = 1'b1; a0 = 24'h400000; b0 = 24'h200000; div_q = 32'h80000000;
    a1 = 24'h00F00F; b1 = 24'h0FF0FF;
    step();
    chk1("drop.start", div_start, 1'b1);
    chk("drop.div_a", 32'(div_a), 32'h400000);
    for (int c = 2; c <= 17; c++) begin
      step();
      if (c == 4) begin req0 = 1'b0; a0 = 24'h000000; end
      if (c == 6) req1 = 1'b1;
      chk1("drop.grant", grant_id, 1'b0);
      chk1("drop.run_start", div_start, 1'b0);
      chk("drop.run_done", 32'({done1, done0}), 32'(0));
      chk("drop.div_a_hold", 32'(div_a), 32'h400000);
    end
    step();
    chk("drop.done", 32'({done1, done0}), 32'(1));
    chk1("drop.done_grant", grant_id, 1'b0);
    chk("drop.q_out", q_out, 32'h80000000);
    chk1("drop.stall1", stall1, 1'b1);
    step();
    chk1("drop.idle_busy", busy, 1'b0);
    chk1("drop.idle_start", div_start, 1'b0);
    step();
    chk1("late.start", div_start, 1'b1);
    chk1("late.grant", grant_id, 1'b1);
    chk("late.div_a", 32'(div_a), 32'h00F00F);
    chk("late.div_b", 32'(div_b), 32'h0FF0FF);
    req1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
